// File: rtl/gth_link_sequencer.sv
// gth_link_sequencer: brings up the SFP0 GTH link carrying the LFSR pattern.
// Sequence: reset pulse -> PLL lock -> reset done -> rx aligned -> UP. Each
// checkpoint is bounded by a timeout. Failed attempts back off and retry up
// to MAX_RETRY times. A filtered loss of link while UP re-runs the sequence.

// Two-flop synchronizer for one asynchronous status bit.
module gth_sync_bit (
  input  logic axi_clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  // meta_q may go metastable; only sync_q is used downstream
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

module gth_link_sequencer #(
  parameter int unsigned RST_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned LOSS_FILT      = 16,
  parameter int unsigned BACKOFF_CYCLES = 1024
) (
  input  logic       axi_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       restart,
  input  logic [3:0] gth_status,
  output logic       gth_rst,
  output logic       link_up,
  output logic       link_fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET      = 3'd1,
    S_WAIT_PLL   = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_WAIT_ALIGN = 3'd4,
    S_UP         = 3'd5,
    S_BACKOFF    = 3'd6,
    S_FAIL       = 3'd7
  } state_t;

  // One shared timer covers reset hold, checkpoint waits, backoff and the
  // loss filter; only one of these is ever active at a time.
  localparam int unsigned M0 = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned M1 = (M0 > BACKOFF_CYCLES) ? M0 : BACKOFF_CYCLES;
  localparam int unsigned M2 = (M1 > LOSS_FILT) ? M1 : LOSS_FILT;
  localparam int unsigned TW = $clog2(M2 + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BO_LAST   = TW'(BACKOFF_CYCLES - 1);
  localparam logic [TW-1:0] LOSS_LAST = TW'(LOSS_FILT - 1);
  localparam logic [TW-1:0] TIM_ONE   = TW'(1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  logic [3:0] s;

  // Per-bit synchronizers; every decision below uses s, never gth_status.
  for (genvar i = 0; i < 4; i++) begin : g_sync
    gth_sync_bit u_sync (
      .axi_clk (axi_clk),
      .rst     (rst),
      .d       (gth_status[i]),
      .q       (s[i])
    );
  end

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          gth_rst_q, gth_rst_d;
  logic          link_up_q, link_up_d;
  logic          link_fail_q, link_fail_d;
  logic          fail_attempt;

  // State, timers and counters; async reset puts outputs at safe values.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      gth_rst_q   <= 1'b1;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      gth_rst_q   <= gth_rst_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
    end
  end

  // Next-state logic: enable drop beats restart beats normal sequencing.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    loss_d       = loss_q;
    fail_attempt = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else if (restart) begin
      state_d = S_RESET;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_RESET;
          timer_d = '0;
        end
        S_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d = S_WAIT_PLL;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIM_ONE;
          end
        end
        // A checkpoint met on the timer's last cycle still counts as success.
        S_WAIT_PLL: begin
          if (s[0]) begin
            state_d = S_WAIT_DONE;
            timer_d = '0;
          end else if (timer_q == TO_LAST) begin
            fail_attempt = 1'b1;
          end else begin
            timer_d = timer_q + TIM_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (s[2:0] == 3'b111) begin
            state_d = S_WAIT_ALIGN;
            timer_d = '0;
          end else if (timer_q == TO_LAST) begin
            fail_attempt = 1'b1;
          end else begin
            timer_d = timer_q + TIM_ONE;
          end
        end
        S_WAIT_ALIGN: begin
          if (s == 4'hF) begin
            state_d = S_UP;
            timer_d = '0;
            retry_d = '0;
          end else if (timer_q == TO_LAST) begin
            fail_attempt = 1'b1;
          end else begin
            timer_d = timer_q + TIM_ONE;
          end
        end
        // Timer acts as the loss filter: counts consecutive bad cycles.
        S_UP: begin
          if (s != 4'hF) begin
            if (timer_q == LOSS_LAST) begin
              state_d = S_RESET;
              timer_d = '0;
              if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end else begin
              timer_d = timer_q + TIM_ONE;
            end
          end else begin
            timer_d = '0;
          end
        end
        S_BACKOFF: begin
          if (timer_q == BO_LAST) begin
            state_d = S_RESET;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIM_ONE;
          end
        end
        S_FAIL: begin
          timer_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase

      if (fail_attempt) begin
        retry_d = retry_q + 4'd1;
        timer_d = '0;
        state_d = (retry_d == RETRY_MAX) ? S_FAIL : S_BACKOFF;
      end
    end
  end

  // Registered outputs decoded from the next state so they track state_q.
  always_comb begin
    gth_rst_d   = 1'b1;
    link_up_d   = 1'b0;
    link_fail_d = 1'b0;
    unique case (state_d)
      S_WAIT_PLL, S_WAIT_DONE, S_WAIT_ALIGN: gth_rst_d = 1'b0;
      S_UP: begin
        gth_rst_d = 1'b0;
        link_up_d = 1'b1;
      end
      S_FAIL:  link_fail_d = 1'b1;
      default: gth_rst_d   = 1'b1;
    endcase
  end

  assign gth_rst   = gth_rst_q;
  assign link_up   = link_up_q;
  assign link_fail = link_fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_gth_link_sequencer.sv
// Directed bench for gth_link_sequencer with small timing parameters.
module tb_gth_link_sequencer;
  logic       axi_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] gth_status = 4'h0;
  logic       gth_rst, link_up, link_fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int vec = 0;
  int errs = 0;

  gth_link_sequencer #(
    .RST_CYCLES(4), .TIMEOUT_CYCLES(16), .MAX_RETRY(2),
    .LOSS_FILT(3), .BACKOFF_CYCLES(8)
  ) dut (
    .axi_clk(axi_clk), .rst(rst), .enable(enable), .restart(restart),
    .gth_status(gth_status), .gth_rst(gth_rst), .link_up(link_up),
    .link_fail(link_fail), .state(state), .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt)
  );

  always #5 axi_clk = ~axi_clk;

  // Advance one cycle; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  // Leaves the bench in "cycle 0": DUT idle, inputs quiet.
  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; restart = 1'b0; gth_status = 4'h0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Status good from cycle 0 so UP is reached on cycle 8.
  task automatic bring_up();
    do_reset();
    gth_status = 4'hF;
    enable = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", state); end
    vec++; if (gth_rst !== 1'b1) begin errs++; $display("FAIL reset_gth_rst got %b exp 1", gth_rst); end
    vec++; if (link_up !== 1'b0 || link_fail !== 1'b0) begin errs++; $display("FAIL reset_flags got up=%b fail=%b exp 0/0", link_up, link_fail); end
    vec++; if (retry_cnt !== 4'd0 || loss_cnt !== 8'd0) begin errs++; $display("FAIL reset_counts got retry=%0d loss=%0d exp 0/0", retry_cnt, loss_cnt); end
    tick();
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL reset_idle_hold got %0d exp 0", state); end
  endtask

  task automatic test_nominal();
    logic [2:0] exp_st;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) gth_status = 4'hF;
      exp_st = (c <= 4) ? 3'd1 : 3'(c - 3);
      vec++; if (state !== exp_st) begin errs++; $display("FAIL nominal_state c=%0d got %0d exp %0d", c, state, exp_st); end
      vec++; if (gth_rst !== (c <= 4)) begin errs++; $display("FAIL nominal_gth_rst c=%0d got %b exp %b", c, gth_rst, (c <= 4)); end
      vec++; if (link_up !== (c == 8)) begin errs++; $display("FAIL nominal_link_up c=%0d got %b exp %b", c, link_up, (c == 8)); end
    end
    vec++; if (retry_cnt !== 4'd0) begin errs++; $display("FAIL nominal_retry got %0d exp 0", retry_cnt); end
  endtask

  task automatic test_pll_fail();
    logic [2:0] exp_st;
    logic [3:0] exp_rt;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (c <= 4)       exp_st = 3'd1;
      else if (c <= 20) exp_st = 3'd2;
      else if (c <= 28) exp_st = 3'd6;
      else if (c <= 32) exp_st = 3'd1;
      else if (c <= 48) exp_st = 3'd2;
      else              exp_st = 3'd7;
      exp_rt = (c < 21) ? 4'd0 : (c < 49) ? 4'd1 : 4'd2;
      vec++; if (state !== exp_st) begin errs++; $display("FAIL pllfail_state c=%0d got %0d exp %0d", c, state, exp_st); end
      vec++; if (retry_cnt !== exp_rt) begin errs++; $display("FAIL pllfail_retry c=%0d got %0d exp %0d", c, retry_cnt, exp_rt); end
      vec++; if (gth_rst !== (exp_st != 3'd2)) begin errs++; $display("FAIL pllfail_gth_rst c=%0d got %b exp %b", c, gth_rst, (exp_st != 3'd2)); end
      vec++; if (link_fail !== (exp_st == 3'd7)) begin errs++; $display("FAIL pllfail_link_fail c=%0d got %b exp %b", c, link_fail, (exp_st == 3'd7)); end
    end
  endtask

  task automatic test_loss();
    bring_up();
    vec++; if (state !== 3'd5) begin errs++; $display("FAIL loss_pre_up got %0d exp 5", state); end
    gth_status = 4'h7;
    repeat (2) tick();
    gth_status = 4'hF;
    repeat (4) tick();
    vec++; if (state !== 3'd5 || link_up !== 1'b1) begin errs++; $display("FAIL loss_glitch2_state got st=%0d up=%b exp 5/1", state, link_up); end
    vec++; if (loss_cnt !== 8'd0) begin errs++; $display("FAIL loss_glitch2_cnt got %0d exp 0", loss_cnt); end
    gth_status = 4'h7;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) gth_status = 4'hF;
      if (k == 4) begin
        vec++; if (state !== 3'd5) begin errs++; $display("FAIL loss_filter_hold got %0d exp 5", state); end
      end
      if (k == 5) begin
        vec++; if (state !== 3'd1) begin errs++; $display("FAIL loss_state got %0d exp 1", state); end
        vec++; if (loss_cnt !== 8'd1) begin errs++; $display("FAIL loss_cnt got %0d exp 1", loss_cnt); end
        vec++; if (link_up !== 1'b0 || gth_rst !== 1'b1) begin errs++; $display("FAIL loss_outputs got up=%b rst=%b exp 0/1", link_up, gth_rst); end
        vec++; if (retry_cnt !== 4'd0) begin errs++; $display("FAIL loss_retry got %0d exp 0", retry_cnt); end
      end
    end
  endtask

  task automatic test_recover();
    do_reset();
    enable = 1'b1;
    repeat (49) tick();
    vec++; if (state !== 3'd7 || link_fail !== 1'b1) begin errs++; $display("FAIL recover_pre got st=%0d fail=%b exp 7/1", state, link_fail); end
    restart = 1'b1;
    gth_status = 4'hF;
    tick();
    restart = 1'b0;
    vec++; if (state !== 3'd1) begin errs++; $display("FAIL recover_state got %0d exp 1", state); end
    vec++; if (retry_cnt !== 4'd0) begin errs++; $display("FAIL recover_retry got %0d exp 0", retry_cnt); end
    vec++; if (link_fail !== 1'b0 || gth_rst !== 1'b1) begin errs++; $display("FAIL recover_outputs got fail=%b rst=%b exp 0/1", link_fail, gth_rst); end
    repeat (7) tick();
    vec++; if (state !== 3'd5 || link_up !== 1'b1) begin errs++; $display("FAIL recover_up got st=%0d up=%b exp 5/1", state, link_up); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    gth_status = 4'h1;
    enable = 1'b1;
    repeat (7) tick();
    vec++; if (state !== 3'd3) begin errs++; $display("FAIL endrop_pre got %0d exp 3", state); end
    enable = 1'b0;
    tick();
    vec++; if (state !== 3'd0 || gth_rst !== 1'b1) begin errs++; $display("FAIL endrop_idle got st=%0d rst=%b exp 0/1", state, gth_rst); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL endrop_restart_ignored got %0d exp 0", state); end
    tick();
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL endrop_stay_idle got %0d exp 0", state); end
  endtask

  task automatic test_async_reset();
    bring_up();
    gth_status = 4'h7;
    repeat (3) tick();
    gth_status = 4'hF;
    repeat (9) tick();
    vec++; if (state !== 3'd5 || loss_cnt !== 8'd1) begin errs++; $display("FAIL arst_pre got st=%0d loss=%0d exp 5/1", state, loss_cnt); end
    #2;
    rst = 1'b1;
    #1;
    vec++; if (gth_rst !== 1'b1 || link_up !== 1'b0) begin errs++; $display("FAIL arst_outputs got rst=%b up=%b exp 1/0", gth_rst, link_up); end
    vec++; if (loss_cnt !== 8'd0 || state !== 3'd0) begin errs++; $display("FAIL arst_state got st=%0d loss=%0d exp 0/0", state, loss_cnt); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_timeout_edge();
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 18) gth_status = 4'h1;
      if (c == 20) begin
        vec++; if (state !== 3'd2 || gth_rst !== 1'b0) begin errs++; $display("FAIL tedge_last_cycle got st=%0d rst=%b exp 2/0", state, gth_rst); end
      end
      if (c == 21) begin
        vec++; if (state !== 3'd3) begin errs++; $display("FAIL tedge_state got %0d exp 3", state); end
        vec++; if (retry_cnt !== 4'd0) begin errs++; $display("FAIL tedge_retry got %0d exp 0", retry_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pll_fail();
    test_loss();
    test_recover();
    test_enable_drop();
    test_async_reset();
    test_timeout_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
